fc_layer_engine: RTL and testbench
==================================

// Module: fc_layer_engine
// PURPOSE
//  Parametrised, time-multiplexed fully-connected layer: one signed MAC computes
//  OUT_NODES neurons over IN_NODES inputs read from external activation/weight/bias RAMs.
//  Optional ReLU per output; optional running argmax giving the class index for the
//  final layer. Multi-layer FC stacks chain instances: each layer's outputs fill the next layer's input RAM.
// PARAMETERS
//  IN_NODES   3   inputs per neuron
//  OUT_NODES  10  neurons in this layer
//  DATA_W     16  signed fixed-point width of activations, weights and bias
//  FRAC_W     8   fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
//  ACC_W      40  signed accumulator width; must be >= 2*DATA_W+clog2(IN_NODES)+1
//  RELU_EN    1   1: negative outputs clamp to 0
//  ARGMAX_EN  1   1: result tracks index of max output; 0: result tied to 0
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  enable     in   1        start request, sampled only in IDLE
//  in_addr    out  IA_W     activation RAM address, IA_W=clog2(IN_NODES)
//  in_data    in   DATA_W   activation, valid 1 cycle after in_addr
//  w_addr     out  WA_W     weight address j*IN_NODES+i, WA_W=clog2(IN_NODES*OUT_NODES)
//  w_data     in   DATA_W   weight, valid 1 cycle after w_addr
//  b_addr     out  OA_W     bias address j, OA_W=clog2(OUT_NODES)
//  b_data     in   DATA_W   bias, valid 1 cycle after b_addr
//  out_valid  out  1        1-cycle strobe: out_data/out_idx valid
//  out_idx    out  OA_W     neuron index j of out_data
//  out_data   out  DATA_W   rescaled, saturated (ReLU'd) neuron output
//  busy       out  1        high in every state except IDLE
//  finished   out  1        1-cycle pulse, layer complete
//  result     out  4        argmax index (zero-extended/truncated to 4 bits), held until next start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and addresses 0; accumulator, argmax max/index cleared.
//  FSM: IDLE -> BIAS -> MAC -> FLUSH -> WRITE -> (BIAS for j+1 | DONE) -> IDLE.
//   IDLE : enable=1 -> BIAS, j=0, result cleared to 0.
//   BIAS : drive b_addr=j (1 cycle).
//   MAC  : IN_NODES cycles, i=0..IN-1 drives in_addr=i, w_addr=j*IN+i. First cycle
//          acc <= sext(b_data)<<<FRAC_W; later cycles acc += in_data*w_data (product of i-1).
//   FLUSH: acc += product of i=IN-1.
//   WRITE: y = acc>>>FRAC_W (arithmetic), saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1],
//          then ReLU if RELU_EN; out_valid=1, out_idx=j, out_data=y; argmax update.
//   DONE : finished=1 for exactly this cycle; result stable; -> IDLE.
//  Latency: enable sampled at edge 0 -> finished high in cycle OUT_NODES*(IN_NODES+3)+1.
//  Argmax: j=0 always loads max; j>0 replaces only if y > max (signed, strict) -> ties keep
//   lowest index. Compare uses post-ReLU y.
//  enable while busy: ignored. enable held high: new run starts the cycle after DONE.
//  Reset mid-run: immediate return to IDLE, no finished/out_valid, partial results dropped.
//  Address outputs hold last value outside their active state; RAMs must tolerate this.
//  No multiplication overflow possible given ACC_W rule; only output stage saturates.
// STRUCTURE
//  fc_pkg: state enum (IDLE,BIAS,MAC,FLUSH,WRITE,DONE), sat_round function,
//   width helper constants/clog2 wrapper.
//  Sub-module fc_argmax_tracker (clk, reset, clear, valid, idx, value -> max_idx, max_val).
//  MAC datapath and FSM stay inline in fc_layer_engine.
// TESTING (IN=3, OUT=10, DATA_W=16, FRAC_W=8; RAM models 1-cycle latency)
//  1 x=[1.0,2.0,-1.0]; neuron 3 weights=[1.0,1.0,1.0], all others 0, bias 0 -> out_data[3]=0x0200,
//    others 0; result=3; finished exactly at cycle 61; 10 out_valid strobes, idx 0..9 in order.
//  2 all weights/bias 0 -> all outputs 0, result=0 (tie keeps lowest index).
//  3 x=[127.0 x3], w=127.0 all, bias 0 -> out_data=0x7FFF every neuron; RELU_EN=1, w=-127.0
//    -> out_data=0 (RELU_EN=0: 0x8000).
//  4 bias[j]=j*0.5 only (0x0080*j), weights 0 -> out_data[j]=j*0x0080, result=9.
//  5 assert reset at cycle 20 of a run -> no finished, outputs 0; re-enable -> full
//    61-cycle run, correct result.
//  6 enable held high for 3 runs -> finished pulses at cycles 61,123,185; enable pulses while
//    busy ignored.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer engine.
// Holds the layer FSM state encoding, width helpers and the output rescale/saturate function.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        FLUSH,
        WRITE,
        DONE
    } fc_state_t;

    localparam int RESULT_W = 4;

    // clog2 that never returns 0, so single-entry address buses stay one bit wide
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic shift back to Q format, then clamp into a data_w-bit signed range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int frac_w,
                                                     input int data_w);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = acc >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (y > hi) begin
            return hi;
        end
        if (y < lo) begin
            return lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running argmax over a stream of signed values; the first value after clear always loads,
// later values replace the held maximum only when strictly greater, so ties keep the lowest index.
module fc_argmax_tracker #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] value,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val
);

    logic first_reg;
    logic take;

    assign take = valid && (first_reg || (signed'(value) > signed'(max_val)));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            max_idx   <= '0;
            max_val   <= '0;
            first_reg <= 1'b1;
        end else if (take) begin
            max_idx   <= idx;
            max_val   <= value;
            first_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer computed neuron by neuron on one signed MAC, reading activations,
// weights and biases from external 1-cycle-latency RAMs; optional ReLU and argmax result.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int IN_NODES  = 3,
    parameter int OUT_NODES = 10,
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int ACC_W     = 40,
    parameter int RELU_EN   = 1,
    parameter int ARGMAX_EN = 1,
    localparam int IA_W     = clog2w(IN_NODES),
    localparam int WA_W     = clog2w(IN_NODES * OUT_NODES),
    localparam int OA_W     = clog2w(OUT_NODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [IA_W-1:0]   in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [OA_W-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    output logic [OA_W-1:0]   out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              finished,
    output logic [3:0]        result
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [IA_W-1:0] I_LAST = IA_W'(IN_NODES - 1);
    localparam logic [OA_W-1:0] J_LAST = OA_W'(OUT_NODES - 1);

    fc_state_t state_reg, state_next;
    logic [OA_W-1:0]          j_reg, j_next;
    logic [IA_W-1:0]          i_reg, i_next;
    logic [IA_W-1:0]          in_addr_reg, in_addr_next;
    logic [WA_W-1:0]          w_addr_reg, w_addr_next;
    logic [OA_W-1:0]          b_addr_reg, b_addr_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic signed [PROD_W-1:0] product;
    logic signed [63:0]       acc_ext;
    logic signed [63:0]       y_sat;
    logic signed [DATA_W-1:0] y;
    logic                     tracker_clear;
    logic [OA_W-1:0]          max_idx;
    logic [DATA_W-1:0]        max_val_unused;
    logic                     sat_hi_unused;

    // RAM data always belongs to the address issued one cycle earlier
    assign product = PROD_W'(signed'(in_data)) * PROD_W'(signed'(w_data));

    always_comb begin
        state_next    = state_reg;
        j_next        = j_reg;
        i_next        = i_reg;
        in_addr_next  = in_addr_reg;
        w_addr_next   = w_addr_reg;
        b_addr_next   = b_addr_reg;
        acc_next      = acc_reg;
        tracker_clear = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next    = BIAS;
                    j_next        = '0;
                    b_addr_next   = '0;
                    tracker_clear = 1'b1;
                end
            end
            BIAS: begin
                state_next   = MAC;
                i_next       = '0;
                in_addr_next = '0;
                // weight rows are contiguous, so the next row starts right after the last one
                w_addr_next  = (j_reg == '0) ? '0 : w_addr_reg + 1'b1;
            end
            MAC: begin
                if (i_reg == '0) begin
                    acc_next = ACC_W'(signed'(b_data)) <<< FRAC_W;
                end else begin
                    acc_next = acc_reg + ACC_W'(product);
                end
                if (i_reg == I_LAST) begin
                    state_next = FLUSH;
                end else begin
                    i_next       = i_reg + 1'b1;
                    in_addr_next = i_reg + 1'b1;
                    w_addr_next  = w_addr_reg + 1'b1;
                end
            end
            FLUSH: begin
                acc_next   = acc_reg + ACC_W'(product);
                state_next = WRITE;
            end
            WRITE: begin
                if (j_reg == J_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next  = BIAS;
                    j_next      = j_reg + 1'b1;
                    b_addr_next = j_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            j_reg       <= '0;
            i_reg       <= '0;
            in_addr_reg <= '0;
            w_addr_reg  <= '0;
            b_addr_reg  <= '0;
            acc_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            j_reg       <= j_next;
            i_reg       <= i_next;
            in_addr_reg <= in_addr_next;
            w_addr_reg  <= w_addr_next;
            b_addr_reg  <= b_addr_next;
            acc_reg     <= acc_next;
        end
    end

    always_comb begin
        acc_ext = 64'(acc_reg);
        y_sat   = sat_round(acc_ext, FRAC_W, DATA_W);
        y       = y_sat[DATA_W-1:0];
        if ((RELU_EN != 0) && y[DATA_W-1]) begin
            y = '0;
        end
    end

    // upper bits are pure sign extension once saturated
    assign sat_hi_unused = ^y_sat[63:DATA_W];

    assign in_addr   = in_addr_reg;
    assign w_addr    = w_addr_reg;
    assign b_addr    = b_addr_reg;
    assign busy      = (state_reg != IDLE);
    assign finished  = (state_reg == DONE);
    assign out_valid = (state_reg == WRITE);
    assign out_idx   = out_valid ? j_reg : '0;
    assign out_data  = out_valid ? y : '0;

    fc_argmax_tracker #(
        .IDX_W  (OA_W),
        .DATA_W (DATA_W)
    ) u_argmax (
        .clk     (clk),
        .reset   (reset),
        .clear   (tracker_clear),
        .valid   (out_valid),
        .idx     (j_reg),
        .value   (y),
        .max_idx (max_idx),
        .max_val (max_val_unused)
    );

    generate
        if (ARGMAX_EN == 0) begin : g_no_argmax
            assign result = '0;
        end else if (OA_W >= RESULT_W) begin : g_trunc
            assign result = max_idx[RESULT_W-1:0];
        end else begin : g_zext
            assign result = {{(RESULT_W - OA_W){1'b0}}, max_idx};
        end
    endgenerate

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: table of layer setups with scoreboarded neuron outputs,
// plus hand-written reset-mid-run, held-enable and enable-while-busy sequences.
module tb_fc_layer_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] out_data;
    logic        busy;
    logic        finished;
    logic [3:0]  result;

    fc_layer_engine #(
        .IN_NODES(3), .OUT_NODES(10), .DATA_W(16), .FRAC_W(8),
        .ACC_W(40), .RELU_EN(1), .ARGMAX_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .finished(finished), .result(result)
    );

    always #5 clk = ~clk;

    logic [15:0] act_mem [4];
    logic [15:0] w_mem   [32];
    logic [15:0] b_mem   [16];

    always @(posedge clk) begin
        in_data <= act_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    typedef struct {
        int          idx;
        logic [15:0] data;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   fin_q[$];
    int   cycle = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] last_out [16];

    always @(posedge clk) cycle <= cycle + 1;

    // DUT observation: neuron strobes and finish pulses (cycle number relative to start edge)
    always @(negedge clk) begin
        if (out_valid) obs_q.push_back('{idx: int'(out_idx), data: out_data});
        if (finished) fin_q.push_back(cycle - t0 + 1);
    end

    typedef struct {
        string       name;
        logic [15:0] x0, x1, x2;
        logic [15:0] w_fill;
        int          special_j;
        logic [15:0] w_special;
        logic [15:0] b_step;
        logic [3:0]  exp_result;
        int          spot_j;
        logic [15:0] spot_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input int j);
        longint acc;
        longint y;
        acc = longint'($signed(b_mem[j])) * 256;
        for (int i = 0; i < 3; i++)
            acc += longint'($signed(act_mem[i])) * longint'($signed(w_mem[j*3+i]));
        y = acc >>> 8;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (y < 0) y = 0;
        return y[15:0];
    endfunction

    task automatic load_vec(input vec_t v);
        for (int a = 0; a < 4; a++) act_mem[a] = 16'h0;
        act_mem[0] = v.x0;
        act_mem[1] = v.x1;
        act_mem[2] = v.x2;
        for (int a = 0; a < 32; a++) w_mem[a] = 16'h0;
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 3; i++)
                w_mem[j*3+i] = (j == v.special_j) ? v.w_special : v.w_fill;
        for (int j = 0; j < 16; j++) b_mem[j] = (j < 10) ? 16'(j * int'(v.b_step)) : 16'h0;
    endtask

    task automatic push_expected();
        for (int j = 0; j < 10; j++) exp_q.push_back('{idx: j, data: model_y(j)});
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        fin_q.delete();
    endtask

    task automatic start_run(input bit hold);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cycle;
        if (!hold) enable = 1'b0;
    endtask

    task automatic wait_finish(input int n_fin, input int budget, input string tag);
        int k;
        k = 0;
        while (fin_q.size() < n_fin && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (fin_q.size() < n_fin) check({tag, "_timeout"}, fin_q.size(), n_fin);
    endtask

    task automatic drain_compare(input string tag);
        obs_t e;
        obs_t o;
        check({tag, "_strobe_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            last_out[o.idx[3:0]] = o.data;
            $display("txn %s idx=%0d data=%04h exp_idx=%0d exp_data=%04h",
                     tag, o.idx, o.data, e.idx, e.data);
            check({tag, "_idx"}, o.idx, e.idx);
            check({tag, "_data"}, o.data, e.data);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        load_vec(v);
        clear_queues();
        push_expected();
        start_run(1'b0);
        wait_finish(1, 200, v.name);
        if (fin_q.size() > 0) check({v.name, "_latency"}, fin_q[0], 61);
        repeat (2) @(negedge clk);
        #1;
        check({v.name, "_single_finish"}, fin_q.size(), 1);
        check({v.name, "_busy_after"}, busy, 0);
        drain_compare(v.name);
        check({v.name, "_result"}, result, v.exp_result);
        check({v.name, "_spot"}, last_out[v.spot_j], v.spot_data);
    endtask

    initial begin
        vecs[0] = '{"single_neuron", 16'h0100, 16'h0200, 16'hFF00, 16'h0000, 3, 16'h0100, 16'h0000, 4'd3, 3, 16'h0200};
        vecs[1] = '{"all_zero",      16'h0100, 16'h0200, 16'h0300, 16'h0000, -1, 16'h0000, 16'h0000, 4'd0, 5, 16'h0000};
        vecs[2] = '{"sat_pos",       16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, -1, 16'h0000, 16'h0000, 4'd0, 9, 16'h7FFF};
        vecs[3] = '{"relu_neg",      16'h7F00, 16'h7F00, 16'h7F00, 16'h8100, -1, 16'h0000, 16'h0000, 4'd0, 4, 16'h0000};
        vecs[4] = '{"bias_ramp",     16'h0100, 16'h0200, 16'h0300, 16'h0000, -1, 16'h0000, 16'h0080, 4'd9, 9, 16'h0480};
        vecs[5] = '{"argmax_mid",    16'h0100, 16'h0100, 16'h0100, 16'h0080, 7, 16'h0180, 16'h0000, 4'd7, 7, 16'h0480};

        load_vec(vecs[1]);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_finished", finished, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_result", result, 0);
        check("reset_addrs", {in_addr, w_addr, b_addr}, 0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k);

        // reset in the middle of a run
        load_vec(vecs[0]);
        clear_queues();
        start_run(1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_result", result, 0);
        check("midreset_addrs", {in_addr, w_addr, b_addr}, 0);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        check("midreset_no_finish", fin_q.size(), 0);
        check("midreset_idle", busy, 0);
        run_vec(0);

        // enable held high across three back-to-back runs
        load_vec(vecs[4]);
        clear_queues();
        for (int r = 0; r < 3; r++) push_expected();
        start_run(1'b1);
        wait_finish(3, 400, "held");
        enable = 1'b0;
        if (fin_q.size() >= 3) begin
            check("held_finish0", fin_q[0], 61);
            check("held_finish1", fin_q[1], 123);
            check("held_finish2", fin_q[2], 185);
        end
        repeat (3) @(negedge clk);
        #1;
        check("held_stops", busy, 0);
        drain_compare("held");
        check("held_result", result, 9);

        // enable pulse while busy is ignored
        load_vec(vecs[5]);
        clear_queues();
        push_expected();
        start_run(1'b0);
        repeat (29) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_finish(1, 200, "busy_pulse");
        if (fin_q.size() > 0) check("busy_pulse_latency", fin_q[0], 61);
        repeat (70) @(negedge clk);
        #1;
        check("busy_pulse_one_run", fin_q.size(), 1);
        check("busy_pulse_idle", busy, 0);
        drain_compare("busy_pulse");
        check("busy_pulse_result", result, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
